sync_fifo_ctrl: RTL

- Single-clock FIFO controller that drives a dp_ram instance on both ports, with iclk and oclk tied to the same clock.
- Accepts a valid/ready input stream and writes it into the RAM.
- Issues RAM reads and absorbs the RAM's 2-cycle read latency in a 3-entry prefetch buffer, so the output is a registered valid/ready stream at full throughput.
- Used wherever a same-clock elastic buffer is needed in front of pixel/LED datapaths.

---
 rtl/sync_fifo_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller in front of a 2-cycle-latency dual-port RAM
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_wr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_rd,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_rdata_valid,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  empty,
    output logic                  full
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic [1:0]            r_inflight;
    logic [1:0]            r_pf_cnt;
    logic [1:0]            r_ign;
    logic [DATA_WIDTH-1:0] r_pf [3];
    logic                  r_out_valid;
    logic [ADDR_WIDTH+1:0] r_level;

    logic       w_acc;
    logic       w_iss;
    logic       w_pop;
    logic       w_ret;
    logic [2:0] w_occ;
    logic [1:0] w_wi;
    logic [1:0] w_pf_nxt;

    assign full      = r_ram_cnt == DEPTH;
    assign in_ready  = !full && !rst;
    assign w_acc     = in_valid && in_ready;
    assign w_pop     = r_out_valid && out_ready;
    // returns only count once the RAM's un-reset read pipeline has flushed stale data
    assign w_ret     = ram_rdata_valid && (r_ign == 2'd0) && (r_inflight != 2'd0);
    assign w_occ     = {1'b0, r_inflight} + {1'b0, r_pf_cnt} - {2'b0, w_pop};
    assign w_iss     = (r_ram_cnt != '0) && (w_occ < 3'd3);
    assign w_wi      = r_pf_cnt - {1'b0, w_pop};
    assign w_pf_nxt  = r_pf_cnt + {1'b0, w_ret} - {1'b0, w_pop};

    assign ram_wr    = w_acc;
    assign ram_waddr = r_wptr;
    assign ram_wdata = in_data;
    assign ram_rd    = w_iss;
    assign ram_raddr = r_rptr;

    assign out_data  = r_pf[0];
    assign out_valid = r_out_valid;
    assign level     = r_level;
    assign empty     = r_level == '0;

    // pointers, RAM occupancy, in-flight reads, total level and post-reset ignore window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= '0;
            r_level    <= '0;
            r_ign      <= 2'd2;
        end else begin
            if (w_acc) r_wptr <= r_wptr + 1'b1;
            if (w_iss) r_rptr <= r_rptr + 1'b1;
            r_ram_cnt  <= r_ram_cnt + (ADDR_WIDTH+1)'(w_acc) - (ADDR_WIDTH+1)'(w_iss);
            r_inflight <= r_inflight + 2'(w_iss) - 2'(w_ret);
            r_level    <= r_level + (ADDR_WIDTH+2)'(w_acc) - (ADDR_WIDTH+2)'(w_pop);
            r_ign      <= (r_ign != 2'd0) ? r_ign - 2'd1 : r_ign;
        end
    end

    // shift-register prefetch buffer; entry 0 is the registered output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pf_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_pf[0]     <= '0;
            r_pf[1]     <= '0;
            r_pf[2]     <= '0;
        end else begin
            r_pf_cnt    <= w_pf_nxt;
            r_out_valid <= w_pf_nxt != 2'd0;
            if (w_pop) begin
                r_pf[0] <= r_pf[1];
                r_pf[1] <= r_pf[2];
            end
            if (w_ret) r_pf[w_wi] <= ram_rdata;
        end
    end
endmodule
